// File: rtl/uart_pkg.sv
// Shared definitions for the hex console formatter: FSM encodings, ASCII
// constants and the nibble-to-character mapping.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_DIGIT = 2'd1;
  localparam state_t S_CR    = 2'd2;
  localparam state_t S_LAST  = 2'd3;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                 input logic       uppercase);
    if (nibble < 4'd10) return ASCII_0 + {4'h0, nibble};
    return (uppercase ? ASCII_UA : ASCII_LA) + {4'h0, nibble - 4'd10};
  endfunction

endpackage

// File: rtl/uart_hex_formatter_if.sv
// Word-in / byte-out handshake bundle between a word producer, the hex
// formatter and the UART transmitter.
interface uart_hex_formatter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [15:0]       words_done;

  // Formatter side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, words_done
  );

  // Producer and transmitter side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, words_done
  );
endinterface

// File: rtl/uart_hex_formatter.sv
// Prints each accepted word as ASCII hex, most significant nibble first,
// followed by CR/LF or a space; every output is registered.
module uart_hex_formatter
  import uart_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit UPPERCASE = 1'b1,
  parameter bit EOL_CRLF  = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  uart_hex_formatter_if.slave   bus
);

  if ((DATA_W % 4) != 0 || DATA_W < 4 || DATA_W > 64) begin : g_bad_width
    $error("uart_hex_formatter: DATA_W must be a multiple of 4 in 4..64");
  end

  localparam logic [3:0] NIB_INIT = 4'(DATA_W / 4 - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_nib_cnt;
  logic [7:0]        r_out_data;
  logic              r_out_valid;
  logic              r_in_ready;
  logic              r_busy;
  logic [15:0]       r_words_done;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_shifted;
  logic [3:0]        w_nib_nxt;
  logic [7:0]        w_data_nxt;
  logic              w_valid_nxt;
  logic [15:0]       w_done_nxt;
  logic              w_out_xfer;

  assign w_out_xfer = r_out_valid && bus.out_ready;
  assign w_shifted  = r_shift << 4;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_nib_nxt   = r_nib_cnt;
    w_data_nxt  = r_out_data;
    w_valid_nxt = r_out_valid;
    w_done_nxt  = r_words_done;

    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (bus.in_valid && r_in_ready) begin
          w_shift_nxt = bus.in_data;
          w_nib_nxt   = NIB_INIT;
          w_data_nxt  = nibble_to_ascii(bus.in_data[DATA_W-1 -: 4], UPPERCASE);
          w_valid_nxt = 1'b1;
          w_state_nxt = S_DIGIT;
        end
      end
      S_DIGIT: begin
        if (w_out_xfer) begin
          if (r_nib_cnt != 4'd0) begin
            w_shift_nxt = w_shifted;
            w_nib_nxt   = r_nib_cnt - 4'd1;
            w_data_nxt  = nibble_to_ascii(w_shifted[DATA_W-1 -: 4], UPPERCASE);
          end else if (EOL_CRLF) begin
            w_data_nxt  = ASCII_CR;
            w_state_nxt = S_CR;
          end else begin
            w_data_nxt  = ASCII_SP;
            w_state_nxt = S_LAST;
          end
        end
      end
      S_CR: begin
        if (w_out_xfer) begin
          w_data_nxt  = ASCII_LF;
          w_state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        if (w_out_xfer) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = r_words_done + 16'd1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // in_ready/busy are registered copies of the next state, so in_ready only
  // rises one edge after reset release and one edge after the last byte.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_nib_cnt    <= 4'd0;
      r_out_data   <= 8'h00;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_words_done <= 16'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples the pre-edge values computed above.
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_nib_cnt    <= w_nib_nxt;
      r_out_data   <= w_data_nxt;
      r_out_valid  <= w_valid_nxt;
      r_in_ready   <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_words_done <= w_done_nxt;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.words_done = r_words_done;

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Bench for uart_hex_formatter: a 32-bit uppercase CR/LF instance and a
// 16-bit lowercase space-terminated instance, checked against a byte scoreboard.
module tb_uart_hex_formatter;

  logic sys_clk;
  logic rst_n;

  uart_hex_formatter_if #(.DATA_W(32)) ifa ();
  uart_hex_formatter_if #(.DATA_W(16)) ifb ();

  uart_hex_formatter #(.DATA_W(32), .UPPERCASE(1'b1), .EOL_CRLF(1'b1)) dut_a (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (ifa.slave)
  );

  uart_hex_formatter #(.DATA_W(16), .UPPERCASE(1'b0), .EOL_CRLF(1'b0)) dut_b (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (ifb.slave)
  );

  typedef struct {
    int          sel;    // 0: dut_a, 1: dut_b
    logic [31:0] word;
    int          rmode;  // 0: out_ready always high, 1: one high / three low
    string       text;   // expected byte stream
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int          xfer_a = 0;
  int          xfer_b = 0;
  int          mode_a = 0;
  int          mode_b = 0;
  int          exp_done_a = 0;
  int          exp_done_b = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic f_rdy(input int sel);
    return (sel == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction

  function automatic logic f_valid(input int sel);
    return (sel == 0) ? ifa.out_valid : ifb.out_valid;
  endfunction

  function automatic logic f_busy(input int sel);
    return (sel == 0) ? ifa.busy : ifb.busy;
  endfunction

  function automatic logic [15:0] f_done(input int sel);
    return (sel == 0) ? ifa.words_done : ifb.words_done;
  endfunction

  function automatic int f_qsize(input int sel);
    return (sel == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic push_exp(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (sel == 0) q_a.push_back(s[i]);
      else          q_b.push_back(s[i]);
    end
  endtask

  task automatic drive_in(input int sel, input logic v, input logic [31:0] w);
    if (sel == 0) begin
      ifa.in_valid = v;
      ifa.in_data  = w;
    end else begin
      ifb.in_valid = v;
      ifb.in_data  = w[15:0];
    end
  endtask

  // Waits (bounded) for in_ready, lets the accepting edge pass, then checks
  // the one-cycle latency to the first out_valid.
  task automatic accept(input int sel, input string tag);
    int n = 0;
    while (!f_rdy(sel) && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (!f_rdy(sel)) begin
      check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    end else begin
      @(posedge sys_clk); #1;
      check({tag, "_first_valid"}, f_valid(sel), 1);
      check({tag, "_ready_low"},   f_rdy(sel),   0);
      check({tag, "_busy"},        f_busy(sel),  1);
    end
  endtask

  task automatic drain(input int sel, input string tag);
    int n = 0;
    while ((f_qsize(sel) != 0 || f_busy(sel)) && n < 2000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check({tag, "_drained"}, (f_qsize(sel) == 0 && !f_busy(sel)), 1);
  endtask

  // Transmitter-like ready: constant, or one cycle high every four.
  initial begin
    int cnt = 0;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      cnt++;
      ifa.out_ready = (mode_a == 0) ? 1'b1 : ((cnt % 4) == 0);
      ifb.out_ready = (mode_b == 0) ? 1'b1 : ((cnt % 4) == 0);
    end
  end

  // Output monitor: scoreboard pop on each transfer, stability under stall.
  initial begin
    logic       stall_a = 1'b0, stall_b = 1'b0;
    logic [7:0] hold_a = 8'h00, hold_b = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        stall_a = 1'b0;
        stall_b = 1'b0;
      end else begin
        if (stall_a) begin
          check("a_hold_valid", ifa.out_valid, 1);
          check("a_hold_data",  ifa.out_data,  hold_a);
        end
        if (ifa.out_valid && ifa.out_ready) begin
          xfer_a++;
          if (q_a.size() == 0) check("a_extra_byte", ifa.out_data, 64'h100);
          else begin
            e = q_a.pop_front();
            check("a_byte", ifa.out_data, e);
          end
        end
        stall_a = ifa.out_valid && !ifa.out_ready;
        hold_a  = ifa.out_data;

        if (stall_b) begin
          check("b_hold_valid", ifb.out_valid, 1);
          check("b_hold_data",  ifb.out_data,  hold_b);
        end
        if (ifb.out_valid && ifb.out_ready) begin
          xfer_b++;
          if (q_b.size() == 0) check("b_extra_byte", ifb.out_data, 64'h100);
          else begin
            e = q_b.pop_front();
            check("b_byte", ifb.out_data, e);
          end
        end
        stall_b = ifb.out_valid && !ifb.out_ready;
        hold_b  = ifb.out_data;
      end
    end
  end

  initial begin
    vec_t vecs[5];
    int   base;
    int   c;
    int   n;
    logic r;

    vecs[0] = '{sel: 0, word: 32'hDEADBEEF, rmode: 0, text: "DEADBEEF\r\n"};
    vecs[1] = '{sel: 1, word: 32'h00000A9F, rmode: 0, text: "0a9f "};
    vecs[2] = '{sel: 0, word: 32'h12345678, rmode: 1, text: "12345678\r\n"};
    vecs[3] = '{sel: 1, word: 32'h0000C0DE, rmode: 1, text: "c0de "};
    vecs[4] = '{sel: 0, word: 32'h0BADF00D, rmode: 1, text: "0BADF00D\r\n"};

    rst_n = 1'b0;
    drive_in(0, 1'b0, 32'h0);
    drive_in(1, 1'b0, 32'h0);
    #12;
    check("rst_in_ready",   ifa.in_ready,   0);
    check("rst_out_valid",  ifa.out_valid,  0);
    check("rst_out_data",   ifa.out_data,   0);
    check("rst_busy",       ifa.busy,       0);
    check("rst_words_done", ifa.words_done, 0);
    check("rst_b_in_ready", ifb.in_ready,   0);

    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    #1;
    check("release_ready_still_low", ifa.in_ready, 0);
    @(posedge sys_clk); #1;
    check("release_ready_high",   ifa.in_ready, 1);
    check("release_b_ready_high", ifb.in_ready, 1);

    // Table-driven words.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].sel == 0) begin mode_a = vecs[i].rmode; base = xfer_a; end
      else                  begin mode_b = vecs[i].rmode; base = xfer_b; end
      push_exp(vecs[i].sel, vecs[i].text);
      drive_in(vecs[i].sel, 1'b1, vecs[i].word);
      accept(vecs[i].sel, $sformatf("vec%0d", i));
      drive_in(vecs[i].sel, 1'b0, vecs[i].word);
      drain(vecs[i].sel, $sformatf("vec%0d", i));
      if (vecs[i].sel == 0) begin
        check($sformatf("vec%0d_bytes", i), xfer_a - base, vecs[i].text.len());
        exp_done_a++;
      end else begin
        check($sformatf("vec%0d_bytes", i), xfer_b - base, vecs[i].text.len());
        exp_done_b++;
      end
      check($sformatf("vec%0d_words_done", i), f_done(vecs[i].sel),
            (vecs[i].sel == 0) ? exp_done_a : exp_done_b);
    end
    mode_a = 0;
    mode_b = 0;

    // Back-to-back with in_valid held: next accept one idle cycle after S_LAST.
    push_exp(0, "00000000\r\n");
    push_exp(0, "FFFFFFFF\r\n");
    drive_in(0, 1'b1, 32'h00000000);
    accept(0, "b2b");
    drive_in(0, 1'b1, 32'hFFFFFFFF);
    c = 0;
    do begin
      r = ifa.in_ready;
      @(posedge sys_clk); #1;
      c++;
    end while (!r && c < 100);
    check("b2b_accept_gap", c, 11);
    drive_in(0, 1'b0, 32'h0);
    drain(0, "b2b");
    exp_done_a += 2;
    check("b2b_words_done", ifa.words_done, exp_done_a);

    // Reset three digits into a word.
    push_exp(0, "CAFEBABE\r\n");
    base = xfer_a;
    drive_in(0, 1'b1, 32'hCAFEBABE);
    accept(0, "abort");
    drive_in(0, 1'b0, 32'h0);
    n = 0;
    while ((xfer_a - base) < 3 && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("abort_three_digits", xfer_a - base, 3);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid",  ifa.out_valid,  0);
    check("abort_in_ready",   ifa.in_ready,   0);
    check("abort_busy",       ifa.busy,       0);
    check("abort_words_done", ifa.words_done, 0);
    q_a.delete();
    q_b.delete();
    exp_done_a = 0;
    exp_done_b = 0;
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    push_exp(0, "CAFEBABE\r\n");
    base = xfer_a;
    drive_in(0, 1'b1, 32'hCAFEBABE);
    accept(0, "after_abort");
    drive_in(0, 1'b0, 32'h0);
    drain(0, "after_abort");
    check("after_abort_bytes", xfer_a - base, 10);
    check("after_abort_words_done", ifa.words_done, 1);

    // words_done wrap from 0xFFFF.
    force dut_a.r_words_done = 16'hFFFF;
    @(posedge sys_clk); #1;
    release dut_a.r_words_done;
    check("wrap_preset", ifa.words_done, 16'hFFFF);
    push_exp(0, "89ABCDEF\r\n");
    drive_in(0, 1'b1, 32'h89ABCDEF);
    accept(0, "wrap");
    drive_in(0, 1'b0, 32'h0);
    drain(0, "wrap");
    check("wrap_words_done", ifa.words_done, 16'h0000);

    repeat (3) @(posedge sys_clk);
    #1;
    check("final_q_a_empty", q_a.size(), 0);
    check("final_q_b_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_hex_formatter.md
Name: uart_hex_formatter

Overview:
Upstream feeder for the UART transmitter. Accepts binary words over a valid/ready handshake and emits each word as ASCII hexadecimal characters, most significant nibble first, followed by an end-of-line sequence. The byte stream goes over a valid/ready handshake that connects directly to the transmitter's data/valid/ready inputs. It lets board-level logic print counters, status and debug words on the serial console.

Parameters:
DATA_W, 32, input word width in bits; must be a multiple of 4 and in the range 4..64.
UPPERCASE, 1, 1 selects 'A'-'F' for nibbles 10-15; 0 selects 'a'-'f'.
EOL_CRLF, 1, 1 appends CR (0x0D) then LF (0x0A); 0 appends a single space (0x20).

Ports:
sys_clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_data  in  DATA_W  word to print
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a word
out_data  out  8  ASCII byte to the transmitter
out_valid  out  1  out_data valid
out_ready  in  1  transmitter accepts the byte
busy  out  1  a word is being emitted
words_done  out  16  count of fully emitted words, wraps at 0xFFFF -> 0

Behaviour:
- Reset (async assert, sync release) values:
  - in_ready=0, out_valid=0, out_data=0x00, busy=0, words_done=0.
  - State=S_IDLE.
  - in_ready rises on the first clock edge after reset release.
- Transfer rules:
  - An input transfer occurs on an edge where in_valid=1 and in_ready=1.
  - An output transfer occurs on an edge where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable. Valid never depends combinationally on ready.
- All outputs are registered. No combinational path from input to output.
- States:
  - S_IDLE: in_ready=1, out_valid=0, busy=0. On an input transfer:
    - latch in_data into a shift register;
    - set nib_cnt = DATA_W/4-1;
    - load out_data with the ASCII code of the top nibble and set out_valid=1 on the same edge;
    - go to S_DIGIT.
    - Latency from input transfer to first out_valid: 1 cycle.
  - S_DIGIT: in_ready=0, busy=1. On an output transfer:
    - if nib_cnt != 0: shift the register left by 4, decrement nib_cnt, and load the next nibble's ASCII code;
    - else, if EOL_CRLF=1: load 0x0D and go to S_CR;
    - else: load 0x20 and go to S_LAST.
  - S_CR: on an output transfer, load 0x0A and go to S_LAST.
  - S_LAST: on an output transfer:
    - out_valid=0;
    - words_done increments by 1;
    - go to S_IDLE.
  - Minimum gap between consecutive words is 1 idle cycle, because in_ready asserts only in S_IDLE.
- Nibble encoding:
  - Nibbles 0-9 map to 0x30+n.
  - Nibbles 10-15 map to 0x41+(n-10) when UPPERCASE=1, or 0x61+(n-10) when UPPERCASE=0.
- Bytes per word: DATA_W/4 + (EOL_CRLF ? 2 : 1). The default configuration emits 10 bytes per word.
- Downstream compatibility: the transmitter drops ready the cycle after it accepts a byte. The formatter must present the next byte immediately, held until ready returns. Exactly one transfer per ready-high acceptance edge.
- Illegal state encodings return to S_IDLE with out_valid=0.
- Reset mid-word: aborts immediately. Partial output is not resumed, and words_done is not incremented for the aborted word.
- in_valid while busy is ignored (in_ready=0). The upstream producer must hold the word.

Decomposition:
- Shared package uart_pkg holds:
  - state typedef with S_IDLE, S_DIGIT, S_CR, S_LAST;
  - ASCII constants ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_SP=0x20, ASCII_0=0x30, ASCII_UA=0x41, ASCII_LA=0x61;
  - pure function nibble_to_ascii(nibble, uppercase).
- No sub-module is needed; this is a single FSM plus datapath. At the top level it is instantiated directly ahead of the transmitter.

Test Plan:
1. Reset release, in_valid=1, in_data=0xDEADBEEF, out_ready=1 constantly -> bytes 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46,0x0D,0x0A. First out_valid 1 cycle after acceptance; words_done=1.
2. UPPERCASE=0, EOL_CRLF=0, DATA_W=16, in_data=0x0A9F -> 0x30,0x61,0x39,0x66,0x20; 5 bytes total.
3. Backpressure: out_ready toggling 1-cycle high / 3-cycles low (transmitter-like), word 0x12345678 -> each byte held stable during the low cycles, no duplicates, no drops; sequence 0x31..0x38,0x0D,0x0A.
4. Back-to-back: in_valid held with words 0x00000000 then 0xFFFFFFFF -> second word accepted only after S_LAST transfer plus 1 idle cycle; outputs "00000000\r\n" then "FFFFFFFF\r\n"; words_done=2.
5. Reset asserted after 3 digits of 0xCAFEBABE -> out_valid=0 and in_ready=0 asynchronously; after release, words_done=0 and the next word prints complete.
6. words_done preset by running 65536 words (or forced) -> wraps from 0xFFFF to 0x0000.
